fetch: RTL

FETCH -- requirements
Module: fetch

---
 rtl/fetch.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fetch.sv
// Instruction fetch: credit-limited requests, in-order responses into a DEPTH-entry buffer, redirect flush with stale drop.
// Response to instr_valid is one registered cycle; requests stall when in-flight plus buffered reaches DEPTH.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {BOOT, FETCH, FLUSH} state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dat;
    } entry_t;

    state_t        r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    entry_t        r_buf [DEPTH];

    logic          w_fire;
    logic          w_rsp;
    logic          w_push;
    logic          w_pop;
    logic          w_credit;
    logic [CW:0]   w_inflight;
    logic [CW-1:0] w_out_rsp;
    logic [31:0]   w_redir_pc;

    assign w_inflight = {1'b0, r_out} + {1'b0, r_cnt};
    assign w_credit   = w_inflight < (CW+1)'(DEPTH);
    assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;

    assign imem_req_valid = (r_state == FETCH) && !redirect_valid && w_credit;
    assign imem_req_addr  = r_pc;
    assign w_fire         = imem_req_valid && imem_req_ready;

    // A response with nothing in flight belongs to a request abandoned by reset.
    assign w_rsp     = imem_rsp_valid && (r_out != '0);
    assign w_push    = w_rsp && (r_state == FETCH) && !redirect_valid;
    assign w_out_rsp = r_out - CW'(w_rsp);

    assign instr_valid = (r_cnt != '0);
    assign instr       = r_buf[r_rd_ptr].dat;
    assign instr_pc    = r_buf[r_rd_ptr].pc;
    assign w_pop       = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= BOOT;
            r_pc     <= {RESET_PC[31:2], 2'b00};
            r_rsp_pc <= {RESET_PC[31:2], 2'b00};
            r_out    <= '0;
            r_drop   <= '0;
            r_cnt    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
        end else begin
            r_out <= w_out_rsp + CW'(w_fire);

            case (r_state)
                BOOT: r_state <= FETCH;
                FETCH, FLUSH: begin
                    if (redirect_valid)
                        r_state <= (w_out_rsp != '0) ? FLUSH : FETCH;
                    else if (r_state == FLUSH && w_rsp && r_drop == CW'(1))
                        r_state <= FETCH;
                end
                default: r_state <= BOOT;
            endcase

            // Everything still in flight at a redirect is stale, including during FLUSH.
            if (redirect_valid)
                r_drop <= w_out_rsp;
            else if (r_state == FLUSH && w_rsp)
                r_drop <= r_drop - CW'(1);

            if (redirect_valid) begin
                r_pc     <= w_redir_pc;
                r_rsp_pc <= w_redir_pc;
            end else begin
                if (w_fire) r_pc     <= r_pc + 32'd4;
                if (w_push) r_rsp_pc <= r_rsp_pc + 32'd4;
            end

            if (redirect_valid) begin
                r_cnt    <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_buf[r_wr_ptr] <= '{pc: r_rsp_pc, dat: imem_rsp_data};
                    r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
                end
                if (w_pop)
                    r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
                if (w_push && !w_pop)
                    r_cnt <= r_cnt + CW'(1);
                else if (!w_push && w_pop)
                    r_cnt <= r_cnt - CW'(1);
            end
        end
    end
endmodule
